stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Upstream timekeeping stage of the stopwatch display path. Maintains an MM:SS count from 00:00 to 59:59 as BCD digits.
- Its digit and blink outputs drive the seven-segment multiplexer directly.
- Supports run/pause, clear, and per-field manual adjust at a faster rate.
- Single clock domain. All rate timing comes from internal clock-enable dividers, not derived clocks.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1, normal count rate (one second per increment).
- ADJ_HZ, 2, adjust-mode increment rate.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear pulse (debounced, one cycle).
- pause  input  1  run/pause toggle pulse (debounced, one cycle).
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  adjust field select; 0 = minutes, 1 = seconds.
- sec0  output  4  seconds ones digit, 0-9.
- sec1  output  3  seconds tens digit, 0-5.
- min0  output  4  minutes ones digit, 0-9.
- min1  output  3  minutes tens digit, 0-5.
- blink  output  1  registered copy of adj; requests display blink.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all digits 0; blink 0.
  - FSM in PAUSED.
  - both divider counters 0.
- Dividers:
  - tick_en pulses one cycle every CLK_HZ/TICK_HZ clocks.
  - adj_en pulses one cycle every CLK_HZ/ADJ_HZ clocks.
  - Counter widths are $clog2 of the divide ratio.
  - Both dividers are zeroed by clr and otherwise free-run.
- FSM states: PAUSED, RUN.
  - A pause pulse toggles the state, taking effect on the next cycle.
  - clr forces PAUSED.
  - adj does not change the state.
- Normal counting: when adj=0, state=RUN and tick_en=1, increment MM:SS by one second.
  - sec0 9->0 carries into sec1.
  - sec1 5 with sec0 9 rolls the seconds to 00 and carries into min0.
  - min0 9 carries into min1.
  - 59:59 -> 00:00 (wrap, no flag).
- Adjust mode (adj=1):
  - Normal counting is suspended.
  - On each adj_en, increment the selected field mod 60 (59->00) with no carry into the other field.
  - Adjust works in both PAUSED and RUN.
  - On leaving adjust, counting resumes on the next tick_en.
- Simultaneous events, in priority order:
  - clr beats all others: digits become 00:00 that cycle, and a same-cycle tick or pause is ignored.
  - tick_en together with pause: the tick is applied using the current state, then the state toggles.
  - A sel change mid-adjust applies from the next adj_en.
- Latency: digits update on the clock edge where the enable is high. Outputs are registered; no combinational path from inputs to outputs.
- blink = adj delayed one cycle.
- Invariant: digits never leave BCD range (sec1, min1 ≤ 5; sec0, min0 ≤ 9).

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds input lap (one-cycle pulse).
  - A lap pulse toggles a hold flag (reset 0; cleared by clr).
  - While hold=1, the outputs show the value latched at the lap pulse, and the internal count keeps advancing.
  - A second lap pulse releases the hold, and the outputs show the live count on the next cycle.
- Not defined: there is no lap port, and the outputs always show the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - digit width constants: ONES_W=4, TENS_W=3.
  - MAX_ONES=9, MAX_TENS=5.
  - state enum {PAUSED, RUN}.
- One sub-module, bcd_mod60_counter:
  - ports: clk, rst_n, clr, inc, ones, tens, carry.
  - carry is a one-cycle pulse on 59->00.
  - Instantiated twice, once for seconds and once for minutes.
  - The top level gates the minutes inc with seconds carry in normal mode, or with adj_en in adjust mode.

Test Plan (use CLK_HZ=8, TICK_HZ=1, ADJ_HZ=2, so tick every 8 clocks and adjust every 4):
- Reset then pause pulse, run 80 clocks -> outputs 00:10, blink=0.
- Preload by running to 00:59, next tick_en -> 01:00; from 59:59, next tick -> 00:00.
- Pause pulse in the same cycle as tick_en while in RUN -> count increments once, then freezes; no change over 40 further clocks.
- adj=1, sel=1 at 00:58, three adj_en -> 00:59, 00:00, 00:01, with minutes unchanged at 00; blink=1 one cycle after adj rises.
- clr asserted in the same cycle as tick_en at 12:34 in RUN -> 00:00 and PAUSED; no increment over the next 16 clocks.
- With STOPWATCH_LAP_HOLD_EN: lap at 00:05, run 24 clocks -> outputs hold at 00:05; second lap -> next cycle shows 00:08.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared digit widths, BCD limits and run-state type for the stopwatch counter.
package stopwatch_pkg;
  localparam int ONES_W = 4;
  localparam int TENS_W = 3;
  localparam logic [ONES_W-1:0] MAX_ONES = 4'd9;
  localparam logic [TENS_W-1:0] MAX_TENS = 3'd5;

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;
endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter 00..59. Carry is high in the cycle whose increment wraps 59->00,
// so a downstream field can advance on the same edge.
module bcd_mod60_counter
  import stopwatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ONES_W-1:0] ones,
  output logic [TENS_W-1:0] tens,
  output logic              carry
);
  assign carry = inc && !clr && (ones == MAX_ONES) && (tens == MAX_TENS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      tens <= '0;
    end else if (clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (ones == MAX_ONES) begin
        ones <= '0;
        tens <= (tens == MAX_TENS) ? '0 : tens + TENS_W'(1);
      end else begin
        ones <= ones + ONES_W'(1);
      end
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run/pause, clear and per-field adjust, timed by clock-enable dividers.
// Optional lap hold is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int ADJ_HZ  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              pause,
  input  logic              adj,
  input  logic              sel,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic              lap,
`endif
  output logic [ONES_W-1:0] sec0,
  output logic [TENS_W-1:0] sec1,
  output logic [ONES_W-1:0] min0,
  output logic [TENS_W-1:0] min1,
  output logic              blink
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ADJ_W    = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;

  logic [TICK_W-1:0] tick_cnt;
  logic [ADJ_W-1:0]  adj_cnt;
  logic              tick_en;
  logic              adj_en;

  assign tick_en = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign adj_en  = (adj_cnt == ADJ_W'(ADJ_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      adj_cnt  <= '0;
    end else begin
      tick_cnt <= (clr || tick_en) ? '0 : tick_cnt + TICK_W'(1);
      adj_cnt  <= (clr || adj_en) ? '0 : adj_cnt + ADJ_W'(1);
    end
  end

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PAUSED;
      blink <= 1'b0;
    end else begin
      blink <= adj;
      if (clr) state <= PAUSED;
      else if (pause) state <= (state == RUN) ? PAUSED : RUN;
    end
  end

  logic              sec_inc, min_inc, sec_carry, min_carry;
  logic [ONES_W-1:0] live_sec0, live_min0;
  logic [TENS_W-1:0] live_sec1, live_min1;

  // Adjust mode bypasses the seconds carry so each field wraps on its own.
  assign sec_inc = adj ? (sel && adj_en) : ((state == RUN) && tick_en);
  assign min_inc = adj ? (!sel && adj_en) : sec_carry;

  bcd_mod60_counter u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (sec_inc),
    .ones  (live_sec0),
    .tens  (live_sec1),
    .carry (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (min_inc),
    .ones  (live_min0),
    .tens  (live_min1),
    .carry (min_carry)
  );

  logic unused_carry;
  assign unused_carry = min_carry;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic              hold;
  logic [ONES_W-1:0] snap_sec0, snap_min0;
  logic [TENS_W-1:0] snap_sec1, snap_min1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= 1'b0;
      snap_sec0 <= '0;
      snap_sec1 <= '0;
      snap_min0 <= '0;
      snap_min1 <= '0;
    end else if (clr) begin
      hold <= 1'b0;
    end else if (lap) begin
      hold <= !hold;
      if (!hold) begin
        snap_sec0 <= live_sec0;
        snap_sec1 <= live_sec1;
        snap_min0 <= live_min0;
        snap_min1 <= live_min1;
      end
    end
  end

  assign sec0 = hold ? snap_sec0 : live_sec0;
  assign sec1 = hold ? snap_sec1 : live_sec1;
  assign min0 = hold ? snap_min0 : live_min0;
  assign min1 = hold ? snap_min1 : live_min1;
`else
  assign sec0 = live_sec0;
  assign sec1 = live_sec1;
  assign min0 = live_min0;
  assign min1 = live_min1;
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed scoreboard bench for stopwatch_counter at CLK_HZ=8 (tick every 8 clocks, adjust every 4).
module tb_stopwatch_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, pause = 1'b0, adj = 1'b0, sel = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap = 1'b0;
`endif
  logic [3:0] sec0, min0;
  logic [2:0] sec1, min1;
  logic       blink;

  int vectors = 0;
  int miscompares = 0;
  int pe;

  typedef struct {
    string tag;
    int    mm;
    int    ss;
    logic  blink;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_HZ(8), .TICK_HZ(1), .ADJ_HZ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .pause (pause),
    .adj   (adj),
    .sel   (sel),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap   (lap),
`endif
    .sec0  (sec0),
    .sec1  (sec1),
    .min0  (min0),
    .min1  (min1),
    .blink (blink)
  );

  // Edges since the dividers were last zeroed: ticks land where pe%8==0, adjusts where pe%4==0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe <= 0;
    else if (clr) pe <= 0;
    else pe <= pe + 1;
  end

  task automatic expect_val(input string tag, input int mm, input int ss, input logic b);
    exp_t e;
    e.tag = tag; e.mm = mm; e.ss = ss; e.blink = b;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [14:0] obs, want;
    e = sb.pop_front();
    obs  = {min1, min0, sec1, sec0, blink};
    want = {3'(e.mm / 10), 4'(e.mm % 10), 3'(e.ss / 10), 4'(e.ss % 10), e.blink};
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d%0d:%0d%0d blink=%b, expected %02d:%02d blink=%b",
             e.tag, min1, min0, sec1, sec0, blink, e.mm, e.ss, e.blink);
    end
  endtask

  task automatic wait_phase(input int div, input int ph, input string tag);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((pe % div) == ph) break;
    end
    vectors++;
    assert ((pe % div) == ph) else begin
      miscompares++;
      $error("FAIL %s: timed out, phase %0d expected %0d", tag, pe % div, ph);
    end
  endtask

  task automatic adj_steps(input int n);
    for (int i = 0; i < n; i++) wait_phase(4, 0, "adj_wait");
  endtask

  initial begin
    int first;
    expect_val("reset", 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check();

    rst_n = 1'b1; pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    expect_val("run80", 0, 10, 1'b0);
    repeat (80) @(negedge clk);
    check();

    adj = 1'b1; sel = 1'b1;
    adj_steps(49);
    expect_val("adj_s59", 0, 59, 1'b1); check();
    adj = 1'b0;
    expect_val("carry_0100", 1, 0, 1'b0);
    wait_phase(8, 0, "tick_wait"); check();

    adj = 1'b1; sel = 1'b0;
    adj_steps(58);
    expect_val("adj_m59", 59, 0, 1'b1); check();
    sel = 1'b1;
    adj_steps(59);
    expect_val("adj_5959", 59, 59, 1'b1); check();
    adj = 1'b0;
    expect_val("wrap_0000", 0, 0, 1'b0);
    wait_phase(8, 0, "tick_wait"); check();

    wait_phase(8, 7, "pre_tick_wait");
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    expect_val("pause_tick", 0, 1, 1'b0); check();
    repeat (40) @(negedge clk);
    expect_val("frozen", 0, 1, 1'b0); check();

    adj = 1'b1; sel = 1'b1;
    @(negedge clk);
    first = ((pe % 4) == 0) ? 1 : 0;
    expect_val("blink_rise", 0, 1 + first, 1'b1); check();
    adj_steps(57 - first);
    expect_val("adj_s58", 0, 58, 1'b1); check();
    adj_steps(1); expect_val("adj_s59b", 0, 59, 1'b1); check();
    adj_steps(1); expect_val("adj_s00", 0, 0, 1'b1); check();
    adj_steps(1); expect_val("adj_s01", 0, 1, 1'b1); check();
    adj = 1'b0;
    @(negedge clk);
    expect_val("blink_fall", 0, 1, 1'b0); check();

    adj = 1'b1; sel = 1'b0;
    adj_steps(12);
    sel = 1'b1;
    adj_steps(33);
    adj = 1'b0;
    wait_phase(8, 7, "pre_tick_wait");
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    wait_phase(8, 7, "pre_tick_wait");
    expect_val("pre_clr", 12, 34, 1'b0); check();
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    expect_val("clr_tick", 0, 0, 1'b0); check();
    repeat (16) @(negedge clk);
    expect_val("clr_paused", 0, 0, 1'b0); check();

`ifdef STOPWATCH_LAP_HOLD_EN
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    repeat (5) wait_phase(8, 0, "tick_wait");
    lap = 1'b1;
    @(negedge clk); lap = 1'b0;
    repeat (24) @(negedge clk);
    expect_val("lap_hold", 0, 5, 1'b0); check();
    lap = 1'b1;
    @(negedge clk); lap = 1'b0;
    expect_val("lap_release", 0, 8, 1'b0); check();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule
